// File: rtl/alu_reservation_station.sv
// Reservation station for integer/branch ops. Buffers issued instructions
// until both operands are known (snooping the ALU and LSB CDBs), then
// launches the lowest-index ready entry into the ALU, one per cycle.
module alu_reservation_station #(
    parameter int RS_SIZE  = 16,
    parameter int OP_WIDTH = 6,
    parameter int ROB_W    = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear_in,
    input  logic                issue_valid,
    input  logic [OP_WIDTH-1:0] issue_op,
    input  logic [DATA_W-1:0]   issue_V1,
    input  logic [DATA_W-1:0]   issue_V2,
    input  logic                issue_Q1_busy,
    input  logic                issue_Q2_busy,
    input  logic [ROB_W-1:0]    issue_Q1,
    input  logic [ROB_W-1:0]    issue_Q2,
    input  logic [DATA_W-1:0]   issue_imm,
    input  logic [ADDR_W-1:0]   issue_pos,
    input  logic [ROB_W-1:0]    issue_rob,
    input  logic                cdb_alu_valid,
    input  logic [ROB_W-1:0]    cdb_alu_tag,
    input  logic [DATA_W-1:0]   cdb_alu_value,
    input  logic                cdb_lsb_valid,
    input  logic [ROB_W-1:0]    cdb_lsb_tag,
    input  logic [DATA_W-1:0]   cdb_lsb_value,
    output logic                rs_full,
    output logic [OP_WIDTH-1:0] alu_op,
    output logic [DATA_W-1:0]   alu_V1,
    output logic [DATA_W-1:0]   alu_V2,
    output logic [DATA_W-1:0]   alu_imm,
    output logic [ADDR_W-1:0]   alu_pos,
    output logic [ROB_W-1:0]    alu_rob
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    typedef struct packed {
        logic                valid;
        logic [OP_WIDTH-1:0] op;
        logic [DATA_W-1:0]   v1;
        logic [DATA_W-1:0]   v2;
        logic                q1_busy;
        logic                q2_busy;
        logic [ROB_W-1:0]    q1;
        logic [ROB_W-1:0]    q2;
        logic [DATA_W-1:0]   imm;
        logic [ADDR_W-1:0]   pos;
        logic [ROB_W-1:0]    rob;
    } rs_entry_t;

    rs_entry_t          ent [RS_SIZE];
    logic [CNT_W-1:0]   count;
    logic [RS_SIZE-1:0] ready;
    logic               disp_hit;
    logic [IDX_W-1:0]   disp_idx;
    logic               free_hit;
    logic [IDX_W-1:0]   free_idx;
    logic               do_issue;
    rs_entry_t          new_ent;

    // Returns {busy, value} after snooping both CDBs; ALU bus wins a tie.
    function automatic logic [DATA_W:0] snoop(input logic busy,
                                              input logic [ROB_W-1:0] tag,
                                              input logic [DATA_W-1:0] val);
        if (busy && cdb_alu_valid && cdb_alu_tag == tag)
            return {1'b0, cdb_alu_value};
        else if (busy && cdb_lsb_valid && cdb_lsb_tag == tag)
            return {1'b0, cdb_lsb_value};
        else
            return {busy, val};
    endfunction

    assign rs_full  = (count == CNT_W'(RS_SIZE));
    assign do_issue = issue_valid && !rs_full && free_hit;

    // Ready vector plus lowest-index ready and lowest-index free slots,
    // all taken from registered state at the start of the cycle.
    always_comb begin
        disp_hit = 1'b0;
        disp_idx = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            ready[i] = ent[i].valid && !ent[i].q1_busy && !ent[i].q2_busy;
            if (ready[i]) begin
                disp_hit = 1'b1;
                disp_idx = IDX_W'(i);
            end
            if (!ent[i].valid) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Incoming entry with same-cycle CDB forwarding applied to its operands.
    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.op    = issue_op;
        new_ent.q1    = issue_Q1;
        new_ent.q2    = issue_Q2;
        new_ent.imm   = issue_imm;
        new_ent.pos   = issue_pos;
        new_ent.rob   = issue_rob;
        {new_ent.q1_busy, new_ent.v1} = snoop(issue_Q1_busy, issue_Q1, issue_V1);
        {new_ent.q2_busy, new_ent.v2} = snoop(issue_Q2_busy, issue_Q2, issue_V2);
    end

    // Entry storage, wake-up, dispatch register and occupancy count.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
            count   <= '0;
            alu_op  <= '0;
            alu_V1  <= '0;
            alu_V2  <= '0;
            alu_imm <= '0;
            alu_pos <= '0;
            alu_rob <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int i = 0; i < RS_SIZE; i++) ent[i].valid <= 1'b0;
                count  <= '0;
                alu_op <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent[i].valid) begin
                        {ent[i].q1_busy, ent[i].v1} <= snoop(ent[i].q1_busy, ent[i].q1, ent[i].v1);
                        {ent[i].q2_busy, ent[i].v2} <= snoop(ent[i].q2_busy, ent[i].q2, ent[i].v2);
                    end
                end
                if (disp_hit) begin
                    ent[disp_idx].valid <= 1'b0;
                    alu_op  <= ent[disp_idx].op;
                    alu_V1  <= ent[disp_idx].v1;
                    alu_V2  <= ent[disp_idx].v2;
                    alu_imm <= ent[disp_idx].imm;
                    alu_pos <= ent[disp_idx].pos;
                    alu_rob <= ent[disp_idx].rob;
                end else begin
                    alu_op <= '0;
                end
                // free slot was invalid at cycle start, so never the dispatched one
                if (do_issue) ent[free_idx] <= new_ent;
                count <= count + CNT_W'(do_issue) - CNT_W'(disp_hit);
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench: per-cycle vector table for single-entry flows, then
// hand-written sequences for fill, flush, stall and async reset.
module tb_alu_reservation_station;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in, issue_valid;
    logic [5:0]  issue_op;
    logic [31:0] issue_V1, issue_V2, issue_imm, issue_pos;
    logic        issue_Q1_busy, issue_Q2_busy;
    logic [3:0]  issue_Q1, issue_Q2, issue_rob;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_tag, cdb_lsb_tag;
    logic [31:0] cdb_alu_value, cdb_lsb_value;
    logic        rs_full;
    logic [5:0]  alu_op;
    logic [31:0] alu_V1, alu_V2, alu_imm, alu_pos;
    logic [3:0]  alu_rob;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    alu_reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_V1(issue_V1), .issue_V2(issue_V2),
        .issue_Q1_busy(issue_Q1_busy), .issue_Q2_busy(issue_Q2_busy),
        .issue_Q1(issue_Q1), .issue_Q2(issue_Q2),
        .issue_imm(issue_imm), .issue_pos(issue_pos), .issue_rob(issue_rob),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_value(cdb_alu_value),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_value(cdb_lsb_value),
        .rs_full(rs_full), .alu_op(alu_op), .alu_V1(alu_V1), .alu_V2(alu_V2),
        .alu_imm(alu_imm), .alu_pos(alu_pos), .alu_rob(alu_rob)
    );

    always #5 clk_in = ~clk_in;

    // protocol monitor: issue while full is a dispatcher bug
    always @(posedge clk_in)
        if (rst_in && rdy_in && !clear_in && issue_valid && rs_full) viol++;

    initial begin
        #200000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        iv;
        logic [5:0]  op;
        logic [31:0] v1, v2;
        logic        q1b;
        logic [3:0]  q1;
        logic        q2b;
        logic [3:0]  q2;
        logic [31:0] imm;
        logic [3:0]  rob;
        logic        av;
        logic [3:0]  at;
        logic [31:0] aval;
        logic        lv;
        logic [3:0]  lt;
        logic [31:0] lval;
        logic [5:0]  e_op;
        logic        all;
        logic [31:0] e_v1, e_v2, e_imm;
        logic [3:0]  e_rob;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic iv, input logic [5:0] op,
        input logic [31:0] v1, input logic [31:0] v2,
        input logic q1b, input logic [3:0] q1, input logic q2b, input logic [3:0] q2,
        input logic [31:0] imm, input logic [3:0] rob,
        input logic av, input logic [3:0] at, input logic [31:0] aval,
        input logic lv, input logic [3:0] lt, input logic [31:0] lval,
        input logic [5:0] e_op, input logic all,
        input logic [31:0] e_v1, input logic [31:0] e_v2, input logic [31:0] e_imm,
        input logic [3:0] e_rob);
        vec_t v;
        v.iv = iv; v.op = op; v.v1 = v1; v.v2 = v2; v.q1b = q1b; v.q1 = q1;
        v.q2b = q2b; v.q2 = q2; v.imm = imm; v.rob = rob;
        v.av = av; v.at = at; v.aval = aval; v.lv = lv; v.lt = lt; v.lval = lval;
        v.e_op = e_op; v.all = all; v.e_v1 = e_v1; v.e_v2 = e_v2; v.e_imm = e_imm; v.e_rob = e_rob;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        clear_in = 0; issue_valid = 0; issue_op = 0; issue_V1 = 0; issue_V2 = 0;
        issue_Q1_busy = 0; issue_Q2_busy = 0; issue_Q1 = 0; issue_Q2 = 0;
        issue_imm = 0; issue_pos = 0; issue_rob = 0;
        cdb_alu_valid = 0; cdb_alu_tag = 0; cdb_alu_value = 0;
        cdb_lsb_valid = 0; cdb_lsb_tag = 0; cdb_lsb_value = 0;
    endtask

    task automatic iss(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic q1b, input logic [3:0] q1, input logic q2b,
                       input logic [3:0] q2, input logic [31:0] imm, input logic [3:0] rob);
        issue_valid = 1; issue_op = op; issue_V1 = v1; issue_V2 = v2;
        issue_Q1_busy = q1b; issue_Q1 = q1; issue_Q2_busy = q2b; issue_Q2 = q2;
        issue_imm = imm; issue_rob = rob; issue_pos = 32'h1000 + 32'(rob) * 4;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rdy_in = 1; rst_in = 0;
        idle();
        #12;
        chk("reset_op", 32'(alu_op), 0);
        chk("reset_full", 32'(rs_full), 0);
        chk("reset_v1", alu_V1, 0);
        chk("reset_rob", 32'(alu_rob), 0);
        rst_in = 1;
        step();

        //           iv op v1     v2 q1b q1 q2b q2  imm rob  av at aval    lv lt lval    e_op all e_v1   e_v2   e_imm e_rob
        tbl[0]  = mk(1,10, 5,     0, 0,  0, 0,  0,  3,  2,   0, 0, 0,      0, 0, 0,      0,   0,  0,     0,     0,    0);
        tbl[1]  = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   0, 0, 0,      0, 0, 0,      10,  1,  5,     0,     3,    2);
        tbl[2]  = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   0, 0, 0,      0, 0, 0,      0,   0,  0,     0,     0,    0);
        tbl[3]  = mk(1, 1, 0,     4, 1,  7, 0,  0,  0,  5,   0, 0, 0,      0, 0, 0,      0,   0,  0,     0,     0,    0);
        tbl[4]  = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   0, 0, 0,      0, 0, 0,      0,   0,  0,     0,     0,    0);
        tbl[5]  = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   0, 0, 0,      0, 0, 0,      0,   0,  0,     0,     0,    0);
        tbl[6]  = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   1, 7, 32'h10, 0, 0, 0,      0,   0,  0,     0,     0,    0);
        tbl[7]  = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   0, 0, 0,      0, 0, 0,      1,   1,  32'h10,4,     0,    5);
        tbl[8]  = mk(1, 2, 9,     0, 0,  0, 1,  3,  0,  6,   0, 0, 0,      1, 3, 32'hAB, 0,   0,  0,     0,     0,    0);
        tbl[9]  = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   0, 0, 0,      0, 0, 0,      2,   1,  9,     32'hAB,0,    6);
        tbl[10] = mk(1, 3, 0,     0, 1,  4, 0,  0,  0,  7,   0, 0, 0,      0, 0, 0,      0,   0,  0,     0,     0,    0);
        tbl[11] = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   1, 4, 32'h11, 1, 4, 32'h22, 0,   0,  0,     0,     0,    0);
        tbl[12] = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   0, 0, 0,      0, 0, 0,      3,   1,  32'h11,0,     0,    7);
        tbl[13] = mk(1, 4, 1,     0, 0,  0, 1,  9,  0,  8,   1, 9, 32'h33, 1, 9, 32'h44, 0,   0,  0,     0,     0,    0);
        tbl[14] = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   0, 0, 0,      0, 0, 0,      4,   1,  1,     32'h33,0,    8);
        tbl[15] = mk(1, 6, 0,     0, 1,  6, 1, 10, 32'h7, 9, 0, 0, 0,      0, 0, 0,      0,   0,  0,     0,     0,    0);
        tbl[16] = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   1,10, 32'h99, 1, 6, 32'h66, 0,   0,  0,     0,     0,    0);
        tbl[17] = mk(0, 0, 0,     0, 0,  0, 0,  0,  0,  0,   0, 0, 0,      0, 0, 0,      6,   1,  32'h66,32'h99,32'h7,9);

        for (int k = 0; k < 18; k++) begin
            idle();
            if (tbl[k].iv) iss(tbl[k].op, tbl[k].v1, tbl[k].v2, tbl[k].q1b, tbl[k].q1,
                               tbl[k].q2b, tbl[k].q2, tbl[k].imm, tbl[k].rob);
            cdb_alu_valid = tbl[k].av; cdb_alu_tag = tbl[k].at; cdb_alu_value = tbl[k].aval;
            cdb_lsb_valid = tbl[k].lv; cdb_lsb_tag = tbl[k].lt; cdb_lsb_value = tbl[k].lval;
            step();
            chk($sformatf("vec%0d_op", k), 32'(alu_op), 32'(tbl[k].e_op));
            chk($sformatf("vec%0d_full", k), 32'(rs_full), 0);
            if (tbl[k].all) begin
                chk($sformatf("vec%0d_v1", k), alu_V1, tbl[k].e_v1);
                chk($sformatf("vec%0d_v2", k), alu_V2, tbl[k].e_v2);
                chk($sformatf("vec%0d_imm", k), alu_imm, tbl[k].e_imm);
                chk($sformatf("vec%0d_rob", k), 32'(alu_rob), 32'(tbl[k].e_rob));
                chk($sformatf("vec%0d_pos", k), alu_pos, 32'h1000 + 32'(tbl[k].e_rob) * 4);
            end
        end

        // no wake-up means no dispatch
        idle(); iss(1, 0, 0, 1, 4'd13, 0, 0, 0, 4'd13); step();
        idle();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("nowake_op", 32'(alu_op), 0);
        end
        clear_in = 1; step(); idle();

        // fill all 16 entries waiting on tag 1
        for (int i = 0; i < 16; i++) begin
            idle(); iss(5, 0, 32'(i), 1, 4'd1, 0, 0, 0, 4'(i)); step();
        end
        chk("fill_full", 32'(rs_full), 1);
        idle(); iss(6, 32'hEE, 0, 0, 0, 0, 0, 0, 4'd15); step();
        chk("overflow_full", 32'(rs_full), 1);
        chk("overflow_op", 32'(alu_op), 0);
        idle(); cdb_alu_valid = 1; cdb_alu_tag = 1; cdb_alu_value = 32'h100; step();
        chk("wake_op", 32'(alu_op), 0);
        chk("wake_full", 32'(rs_full), 1);
        idle();
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("drain%0d_op", i), 32'(alu_op), 5);
            chk($sformatf("drain%0d_v1", i), alu_V1, 32'h100);
            chk($sformatf("drain%0d_v2", i), alu_V2, 32'(i));
            if (i == 0) chk("drain0_full", 32'(rs_full), 0);
        end
        step();
        chk("drain_end_op", 32'(alu_op), 0);
        chk("viol_count", 32'(viol), 1);

        // flush with a same-cycle issue
        for (int i = 0; i < 4; i++) begin
            idle(); iss(7, 0, 0, 1, 4'd2, 0, 0, 0, 4'(i)); step();
        end
        idle(); iss(8, 1, 1, 0, 0, 0, 0, 0, 4'd4); clear_in = 1; step();
        chk("clear_op", 32'(alu_op), 0);
        chk("clear_full", 32'(rs_full), 0);
        idle(); cdb_alu_valid = 1; cdb_alu_tag = 2; cdb_alu_value = 32'h5; step();
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("postclear_op", 32'(alu_op), 0);
        end
        // count must be back to zero: 15 more entries leave one free
        for (int i = 0; i < 15; i++) begin
            idle(); iss(7, 0, 0, 1, 4'd12, 0, 0, 0, 4'(i)); step();
        end
        chk("count15_full", 32'(rs_full), 0);
        idle(); iss(7, 0, 0, 1, 4'd12, 0, 0, 0, 4'd15); step();
        chk("count16_full", 32'(rs_full), 1);
        idle(); clear_in = 1; step(); idle();

        // stall: no dispatch, no capture, outputs frozen
        idle(); iss(10, 0, 0, 1, 4'd5, 0, 0, 0, 4'd4); step();
        idle(); iss(9, 32'h77, 0, 0, 0, 0, 0, 0, 4'd3); step();
        chk("stall_pre_op", 32'(alu_op), 0);
        idle(); rdy_in = 0; iss(11, 0, 0, 0, 0, 0, 0, 0, 4'd6);
        cdb_alu_valid = 1; cdb_alu_tag = 5; cdb_alu_value = 32'h55;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_op", 32'(alu_op), 0);
        end
        idle(); rdy_in = 1; step();
        chk("resume_op", 32'(alu_op), 9);
        chk("resume_v1", alu_V1, 32'h77);
        chk("resume_rob", 32'(alu_rob), 3);
        rdy_in = 0; step();
        chk("freeze_op", 32'(alu_op), 9);
        rdy_in = 1; cdb_alu_valid = 1; cdb_alu_tag = 5; cdb_alu_value = 32'h66; step();
        chk("late_wake_op", 32'(alu_op), 0);
        idle(); step();
        chk("late_disp_op", 32'(alu_op), 10);
        chk("late_disp_v1", alu_V1, 32'h66);
        chk("late_disp_rob", 32'(alu_rob), 4);

        // async reset between edges
        #2 rst_in = 0;
        #1;
        chk("areset_op", 32'(alu_op), 0);
        chk("areset_v1", alu_V1, 0);
        chk("areset_rob", 32'(alu_rob), 0);
        chk("areset_full", 32'(rs_full), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
